sipo_stream: RTL and testbench
==============================

// Module: sipo_stream
// PURPOSE
//  Parametrised serial-in/parallel-out deserialiser with handshakes on both sides.
//  Collects WIDTH serial bits, MSB- or LSB-first, and publishes each completed word.
//  The output is a single-entry holding register with valid/ready backpressure.
//  Sits between a bit-serial link front end and word-wide downstream logic.
// PARAMETERS
//  WIDTH      8  bits per parallel word (>=2)
//  MSB_FIRST  1  1: first serial bit lands in data_o[WIDTH-1]; 0: first bit lands in data_o[0]
// PORTS
//  clk_i    in   1                    clock; all state updates on rising edge
//  rst_n_i  in   1                    asynchronous reset, active-low
//  sync_i   in   1                    word alignment: discard any partial word
//  data_i   in   1                    serial data bit
//  valid_i  in   1                    data_i is valid this cycle
//  ready_o  out  1                    block can accept a serial bit this cycle
//  data_o   out  WIDTH                completed parallel word
//  valid_o  out  1                    data_o holds an undelivered word
//  ready_i  in   1                    downstream accepts data_o this cycle
//  count_o  out  $clog2(WIDTH+1)      bits currently held in the partial word
// BEHAVIOUR
//  - Reset (rst_n_i low, async): shift reg=0, count_o=0, data_o=0, valid_o=0. ready_o=1 after release.
//  - Bit accept: valid_i && ready_o at a rising edge.
//    - MSB_FIRST=1: shift reg <= {sr[WIDTH-2:0], data_i}.
//    - MSB_FIRST=0: shift reg <= {data_i, sr[WIDTH-1:1]}.
//    - count_o increments by 1.
//  - Word complete: accepting a bit while count_o==WIDTH-1:
//    - the full word, including this bit, loads data_o on the same edge.
//    - valid_o=1 from the cycle after that edge; count_o returns to 0.
//    - Latency: last bit edge -> valid_o high 1 cycle later.
//  - Output handshake: the word leaves on an edge with valid_o && ready_i.
//    - valid_o then drops, unless a new word completes on the same edge.
//    - data_o is stable while valid_o=1 && !ready_i.
//  - ready_o = !(valid_o && !ready_i && count_o==WIDTH-1). Combinational from state and ready_i.
//    - Partial-word bits are always accepted.
//    - Only the bit that would complete a second word stalls.
//  - Simultaneous drain and completion (valid_o && ready_i && completing bit):
//    - old word is delivered; new word loads data_o; valid_o stays 1.
//  - sync_i=1 at an edge: partial word cleared (count_o=0, shift reg=0).
//    - If valid_i && ready_o on the same edge, data_i becomes bit 0 of the new word (count_o=1).
//    - sync_i never affects data_o or valid_o.
//  - valid_i low: shift reg and count_o hold.
//  - Reset mid-word or with valid_o=1: partial and pending words are lost, no output pulse.
//  - No X on outputs after reset; data_o is don't-care only by convention when valid_o=0.
//    It is still driven from its register.
// STRUCTURE
//  - Shared package sipo_pkg:
//    - function cnt_w(WIDTH) = $clog2(WIDTH+1).
//    - typedef enum {SHIFT_MSB_FIRST, SHIFT_LSB_FIRST} sipo_order_e.
//  - Sub-module sipo_out_buf: WIDTH-wide single-entry valid/ready register.
//    - Ports: load, word, data_o, valid_o, ready_i, full_stall.
//  - Top level holds the shift register, the bit counter and the ready_o logic.
// TESTING (benches at WIDTH=4 unless noted)
//  1. Reset, then bits 1,0,1,1 with valid_i=1 and MSB_FIRST=1.
//     -> data_o=4'b1011, valid_o high on the cycle after the 4th bit; count_o walks 1,2,3,0.
//  2. Same bits with MSB_FIRST=0 -> data_o=4'b1101.
//  3. ready_i=0 with a second word streaming.
//     -> first word held; after 3 more bits count_o=3 and ready_o=0.
//     -> raising ready_i delivers 1011; the 4th bit is then accepted and the second word appears.
//  4. Back-to-back words with ready_i=1 throughout.
//     -> valid_o stays high across the boundary, data_o updates every 4 cycles, no bit stalls.
//  5. Two bits, then sync_i=1 with valid_i=1 and data_i=1, then 0,0,1.
//     -> count_o=1 after sync; word=4'b1001; the earlier bits are discarded.
//  6. Assert rst_n_i low mid-clock-cycle with valid_o=1 and count_o=2.
//     -> valid_o, count_o and data_o go to 0 immediately, before the next edge.
//  7. WIDTH=8 regression: 100 random words under random valid_i/ready_i.
//     -> scoreboard matches every word in order; no loss, no duplication.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserialiser.
package sipo_pkg;

  typedef enum logic {
    SHIFT_MSB_FIRST,
    SHIFT_LSB_FIRST
  } sipo_order_e;

  // Width of a counter that must hold values 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// Single-entry output holding register with valid/ready handshake.
// A load always wins over a drain, so drain+load on one edge keeps valid_o high.
module sipo_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             full_stall
);

  // Entry is occupied and will not be freed on the coming edge.
  assign full_stall = valid_o && !ready_i;

  // Capture a completed word, or retire the held one when downstream takes it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (load) begin
      data_o  <= word;
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_stream.sv
// Serial-in/parallel-out deserialiser with valid/ready on both sides.
// Holds the shift register and bit counter; completed words go to sipo_out_buf.
module sipo_stream
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      sync_i,
  input  logic                      data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [WIDTH-1:0]          data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [cnt_w(WIDTH)-1:0]   count_o
);

  localparam int          CW    = cnt_w(WIDTH);
  localparam sipo_order_e ORDER = (MSB_FIRST != 0) ? SHIFT_MSB_FIRST : SHIFT_LSB_FIRST;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] sr_shift;
  logic [CW-1:0]    cnt_q;
  logic             last_bit;
  logic             accept;
  logic             load;
  logic             full_stall;

  assign last_bit = (cnt_q == LAST_CNT);
  // Only the bit that would complete a word while the output entry stays full is held off.
  assign ready_o  = !(full_stall && last_bit);
  assign accept   = valid_i && ready_o;
  // A sync restarts the word, so the bit arriving with it can never complete one.
  assign load     = accept && last_bit && !sync_i;
  assign count_o  = cnt_q;

  // Next shift-register value if the current bit is taken; sync shifts into a cleared word.
  always_comb begin
    sr_base  = sync_i ? '0 : sr_q;
    sr_shift = sr_base;
    if (ORDER == SHIFT_MSB_FIRST) begin
      sr_shift = {sr_base[WIDTH-2:0], data_i};
    end else begin
      sr_shift = {data_i, sr_base[WIDTH-1:1]};
    end
  end

  // Shift register and bit counter; sync discards the partial word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      if (load) begin
        sr_q  <= '0;
        cnt_q <= '0;
      end else begin
        sr_q  <= sr_shift;
        cnt_q <= sync_i ? CW'(1) : cnt_q + CW'(1);
      end
    end else if (sync_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end
  end

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load       (load),
    .word       (sr_shift),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .full_stall (full_stall)
  );

endmodule

// File: tb/tb_sipo_stream.sv
// Scoreboard bench for sipo_stream: three instances (W4 MSB-first, W4 LSB-first, W8 MSB-first).
module tb_sipo_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // DUT A: WIDTH=4, MSB first
  logic       a_rst_n, a_sync, a_din, a_vin, a_rdy_i;
  logic       a_rdy_o, a_vout;
  logic [3:0] a_dout;
  logic [2:0] a_cnt;
  // DUT B: WIDTH=4, LSB first
  logic       b_rst_n, b_sync, b_din, b_vin, b_rdy_i;
  logic       b_rdy_o, b_vout;
  logic [3:0] b_dout;
  logic [2:0] b_cnt;
  // DUT C: WIDTH=8, MSB first
  logic       c_rst_n, c_sync, c_din, c_vin, c_rdy_i;
  logic       c_rdy_o, c_vout;
  logic [7:0] c_dout;
  logic [3:0] c_cnt;

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [7:0] qc[$];

  sipo_stream #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
    .clk_i(clk), .rst_n_i(a_rst_n), .sync_i(a_sync), .data_i(a_din), .valid_i(a_vin),
    .ready_o(a_rdy_o), .data_o(a_dout), .valid_o(a_vout), .ready_i(a_rdy_i), .count_o(a_cnt)
  );
  sipo_stream #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
    .clk_i(clk), .rst_n_i(b_rst_n), .sync_i(b_sync), .data_i(b_din), .valid_i(b_vin),
    .ready_o(b_rdy_o), .data_o(b_dout), .valid_o(b_vout), .ready_i(b_rdy_i), .count_o(b_cnt)
  );
  sipo_stream #(.WIDTH(8), .MSB_FIRST(1)) dut_c (
    .clk_i(clk), .rst_n_i(c_rst_n), .sync_i(c_sync), .data_i(c_din), .valid_i(c_vin),
    .ready_o(c_rdy_o), .data_o(c_dout), .valid_o(c_vout), .ready_i(c_rdy_i), .count_o(c_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  // Monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (a_rst_n && a_vout && a_rdy_i) begin
      if (qa.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected_word: got %0h, expected none", a_dout);
      end else check("a_word", a_dout, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b_rst_n && b_vout && b_rdy_i) begin
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected_word: got %0h, expected none", b_dout);
      end else check("b_word", b_dout, qb.pop_front());
    end
  end

  always @(negedge clk) begin
    if (c_rst_n && c_vout && c_rdy_i) begin
      if (qc.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL c_unexpected_word: got %0h, expected none", c_dout);
      end else check("c_word", c_dout, qc.pop_front());
    end
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    summary();
    $finish;
  end

  initial begin
    logic [3:0] w;
    logic [7:0] wc;
    logic [3:0] t4 [3];
    int  guard;
    bit  acc;
    bit  stuck;

    a_rst_n = 0; a_sync = 0; a_din = 0; a_vin = 0; a_rdy_i = 0;
    b_rst_n = 0; b_sync = 0; b_din = 0; b_vin = 0; b_rdy_i = 0;
    c_rst_n = 0; c_sync = 0; c_din = 0; c_vin = 0; c_rdy_i = 0;
    #12;
    check("rst_cnt", a_cnt, 0);
    check("rst_valid", a_vout, 0);
    check("rst_data", a_dout, 0);
    check("rst_c_valid", c_vout, 0);
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1; b_rst_n = 1; c_rst_n = 1;
    #1;
    check("rst_ready", a_rdy_o, 1);

    // 1: MSB first, bits 1,0,1,1
    a_rdy_i = 1;
    w = 4'b1011;
    qa.push_back(4'b1011);
    for (int i = 3; i >= 0; i--) begin
      a_vin = 1; a_din = w[i];
      step();
      check("t1_cnt", a_cnt, (i == 0) ? 0 : 4 - i);
      check("t1_valid", a_vout, (i == 0) ? 1 : 0);
    end
    check("t1_data", a_dout, 4'b1011);
    a_vin = 0;
    step();
    check("t1_valid_drop", a_vout, 0);

    // 2: LSB first, same bits
    b_rdy_i = 1;
    qb.push_back(4'b1101);
    for (int i = 3; i >= 0; i--) begin
      b_vin = 1; b_din = w[i];
      step();
      check("t2_cnt", b_cnt, (i == 0) ? 0 : 4 - i);
    end
    check("t2_data", b_dout, 4'b1101);
    check("t2_valid", b_vout, 1);
    b_vin = 0;
    step();

    // 3: backpressure, second word stalls on its last bit
    a_rdy_i = 0;
    qa.push_back(4'b1011);
    qa.push_back(4'b0110);
    for (int i = 3; i >= 0; i--) begin
      a_vin = 1; a_din = w[i];
      step();
    end
    check("t3_valid_held", a_vout, 1);
    w = 4'b0110;
    for (int i = 3; i >= 1; i--) begin
      a_vin = 1; a_din = w[i];
      step();
    end
    check("t3_cnt3", a_cnt, 3);
    check("t3_ready_low", a_rdy_o, 0);
    a_din = w[0];
    step();
    check("t3_cnt_stalled", a_cnt, 3);
    check("t3_data_stable", a_dout, 4'b1011);
    a_rdy_i = 1;
    #1;
    check("t3_ready_back", a_rdy_o, 1);
    step();
    check("t3_data2", a_dout, 4'b0110);
    check("t3_valid2", a_vout, 1);
    check("t3_cnt0", a_cnt, 0);
    a_vin = 0;
    step();
    check("t3_valid_drop", a_vout, 0);

    // 4: back-to-back words, no stalls
    t4[0] = 4'b1100; t4[1] = 4'b0011; t4[2] = 4'b1110;
    for (int k = 0; k < 3; k++) qa.push_back(t4[k]);
    for (int k = 0; k < 3; k++) begin
      w = t4[k];
      for (int i = 3; i >= 0; i--) begin
        a_vin = 1; a_din = w[i];
        step();
        check("t4_ready", a_rdy_o, 1);
        if (i == 0) begin
          check("t4_valid", a_vout, 1);
          check("t4_data", a_dout, w);
        end
      end
    end
    a_vin = 0;
    step();

    // 5: sync with a bit on the same edge
    qa.push_back(4'b1001);
    a_vin = 1; a_din = 1; step();
    a_din = 1; step();
    check("t5_cnt2", a_cnt, 2);
    a_sync = 1; a_din = 1; step();
    a_sync = 0;
    check("t5_cnt_sync", a_cnt, 1);
    a_din = 0; step();
    a_din = 0; step();
    a_din = 1; step();
    check("t5_data", a_dout, 4'b1001);
    check("t5_valid", a_vout, 1);
    a_vin = 0;
    step();

    // 6: async reset mid-cycle with a pending word and a partial word
    a_rdy_i = 0;
    w = 4'b0101;
    for (int i = 3; i >= 0; i--) begin
      a_vin = 1; a_din = w[i];
      step();
    end
    a_din = 1; step();
    a_din = 1; step();
    a_vin = 0;
    check("t6_pre_valid", a_vout, 1);
    check("t6_pre_cnt", a_cnt, 2);
    #2;
    a_rst_n = 0;
    #1;
    check("t6_valid", a_vout, 0);
    check("t6_cnt", a_cnt, 0);
    check("t6_data", a_dout, 0);
    step();
    a_rst_n = 1;
    step();
    check("t6_ready", a_rdy_o, 1);
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);

    // 7: WIDTH=8, random words under random valid/ready
    stuck = 0;
    for (int n = 0; n < 100 && !stuck; n++) begin
      wc = 8'($urandom);
      qc.push_back(wc);
      for (int i = 7; i >= 0 && !stuck; i--) begin
        acc = 0;
        guard = 0;
        while (!acc && !stuck) begin
          c_rdy_i = ($urandom_range(0, 2) != 0);
          c_vin   = ($urandom_range(0, 3) != 0);
          c_din   = c_vin ? wc[i] : 1'($urandom);
          #1;
          acc = c_vin && c_rdy_o;
          step();
          guard++;
          if (guard > 200) begin
            n_cmp++; n_err++;
            $display("FAIL t7_bit_stall: got no accept, expected accept within 200 cycles");
            stuck = 1;
          end
        end
      end
    end
    c_vin = 0;
    c_rdy_i = 1;
    guard = 0;
    while (qc.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    check("c_queue_empty", qc.size(), 0);

    summary();
    $finish;
  end

endmodule
